// File: rtl/display_scan_pkg.sv
// rtl/display_scan_pkg.sv - shared digit indices, segment patterns and time-snapshot type
package display_scan_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [2:0] idx_t;

  localparam idx_t IDX_S1 = 3'd0;
  localparam idx_t IDX_S2 = 3'd1;
  localparam idx_t IDX_M1 = 3'd2;
  localparam idx_t IDX_M2 = 3'd3;
  localparam idx_t IDX_H1 = 3'd4;
  localparam idx_t IDX_H2 = 3'd5;

  // Active-high patterns, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef struct packed {
    logic [3:0] h2;
    logic [3:0] h1;
    logic [3:0] m2;
    logic [3:0] m1;
    logic [3:0] s2;
    logic [3:0] s1;
  } time_t;

  function automatic idx_t next_idx(input idx_t i);
    return (i == IDX_H2) ? IDX_S1 : i + 3'd1;
  endfunction

  function automatic logic [3:0] pick_digit(input time_t t, input idx_t i);
    case (i)
      IDX_S1:  return t.s1;
      IDX_S2:  return t.s2;
      IDX_M1:  return t.m1;
      IDX_M2:  return t.m2;
      IDX_H1:  return t.h1;
      default: return t.h2;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_bcd_to_seg.sv
// rtl/display_scan_bcd_to_seg.sv - BCD digit to active-high 7-segment pattern, dash for 10-15
module bcd_to_seg
  import display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - six-digit multiplexed 7-segment scanner with per-frame time snapshot
module display_scan
  import display_scan_pkg::*;
#(
  parameter int REFRESH_DIV     = 1000,
  parameter int GUARD           = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int BLANK_LEAD_ZERO = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic       sec_tick,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int              PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]   GUARD_W    = PW'(GUARD);
  localparam logic            POL        = (ACTIVE_LOW != 0);
  localparam logic            LEAD_BLANK = (BLANK_LEAD_ZERO != 0);

  logic [PW-1:0]         presc_q, presc_d;
  idx_t                  idx_q, idx_d;
  time_t                 snap_q, snap_d;
  logic                  dp_phase_q, dp_phase_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  slot_end;
  logic [3:0]            cur_digit;
  logic [6:0]            dec_seg;
  logic                  lead_dark;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_hi;

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Scan timing and the frame-start snapshot keep running regardless of blank
  always_comb begin
    slot_end   = (presc_q == PRESC_LAST);
    presc_d    = slot_end ? '0 : presc_q + PW'(1);
    idx_d      = slot_end ? next_idx(idx_q) : idx_q;
    snap_d     = snap_q;
    if (slot_end && idx_q == IDX_H2) begin
      snap_d = {h2, h1, m2, m1, s2, s1};
    end
    dp_phase_d = dp_phase_q ^ sec_tick;
  end

  // Outputs are computed active-high, then inverted once when ACTIVE_LOW
  always_comb begin
    cur_digit = pick_digit(snap_q, idx_q);
    lead_dark = LEAD_BLANK && (idx_q == IDX_H2) && (snap_q.h2 == 4'd0);
    lit       = !blank && (presc_q >= GUARD_W) && !lead_dark;
    an_hi     = '0;
    if (lit) begin
      an_hi[idx_q] = 1'b1;
    end
    an_d  = an_hi ^ {NUM_DIGITS{POL}};
    seg_d = (lit ? dec_seg : 7'd0) ^ {7{POL}};
    dp_d  = (lit && dp_phase_q && (idx_q == IDX_M1 || idx_q == IDX_H1)) ^ POL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= IDX_S1;
      snap_q     <= '0;
      dp_phase_q <= 1'b0;
      an_q       <= {NUM_DIGITS{POL}};
      seg_q      <= {7{POL}};
      dp_q       <= POL;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      dp_phase_q <= dp_phase_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - randomized bench for display_scan against a cycle-count reference model
module tb_display_scan;

  localparam int DIV = 4;
  localparam int GRD = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] din [6];
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int checks = 0;
  int errors = 0;

  int         t;
  int         snap_m [6];
  bit         ph_m;
  logic [6:0] segtab [16];
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always #5 clk = ~clk;

  display_scan #(
    .REFRESH_DIV     (DIV),
    .GUARD           (GRD),
    .ACTIVE_LOW      (1),
    .BLANK_LEAD_ZERO (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s1       (din[0]),
    .s2       (din[1]),
    .m1       (din[2]),
    .m2       (din[3]),
    .h1       (din[4]),
    .h2       (din[5]),
    .sec_tick (sec_tick),
    .blank    (blank),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 6; i++) snap_m[i] = 0;
    ph_m = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"}, 32'(an), 32'h3F);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge after checking.
  task automatic tick();
    int slot;
    int pos;
    bit on;
    slot = (t / DIV) % 6;
    pos  = t % DIV;
    on   = !blank && (pos >= GRD) && !(slot == 5 && snap_m[5] == 0);
    exp_an  = on ? ~(6'd1 << slot) : 6'h3F;
    exp_seg = on ? ~segtab[snap_m[slot]] : 7'h7F;
    exp_dp  = !(on && ph_m && (slot == 2 || slot == 4));
    if (pos == DIV - 1 && slot == 5)
      for (int i = 0; i < 6; i++) snap_m[i] = int'(din[i]);
    if (sec_tick) ph_m = !ph_m;
    t++;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("an@%0d", t), 32'(an), 32'(exp_an));
    check($sformatf("seg@%0d", t), 32'(seg), 32'(exp_seg));
    check($sformatf("dp@%0d", t), 32'(dp), 32'(exp_dp));
    check($sformatf("onehot@%0d", t), 32'($countones(~an) <= 1), 32'h1);
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    din[5] = 4'(hh / 10); din[4] = 4'(hh % 10);
    din[3] = 4'(mm / 10); din[2] = 4'(mm % 10);
    din[1] = 4'(ss / 10); din[0] = 4'(ss % 10);
  endtask

  initial begin
    segtab[0] = 7'h3F; segtab[1] = 7'h06; segtab[2] = 7'h5B; segtab[3] = 7'h4F;
    segtab[4] = 7'h66; segtab[5] = 7'h6D; segtab[6] = 7'h7D; segtab[7] = 7'h07;
    segtab[8] = 7'h7F; segtab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) segtab[i] = 7'h40;
    for (int i = 0; i < 6; i++) din[i] = 4'd0;

    repeat (3) @(negedge clk);
    check_dark("reset");
    reset = 1'b0;
    model_reset();
    repeat (24) tick();

    set_time(12, 34, 56);
    repeat (48) tick();

    repeat (6) tick();
    din[0] = 4'd7;
    repeat (30) tick();

    din[0] = 4'hC; din[5] = 4'd0; din[4] = 4'd9;
    repeat (48) tick();

    set_time(23, 59, 58);
    sec_tick = 1'b1; tick(); sec_tick = 1'b0;
    repeat (30) tick();
    sec_tick = 1'b1; tick(); sec_tick = 1'b0;
    repeat (30) tick();

    blank = 1'b1;
    repeat (10) tick();
    blank = 1'b0;
    repeat (20) tick();

    sec_tick = 1'b1; tick(); sec_tick = 1'b0;
    for (int i = 0; i < 30 && an == 6'h3F; i++) tick();
    check("lit_before_reset", 32'(an != 6'h3F), 32'h1);
    #1 reset = 1'b1;
    #1 check_dark("async_reset");
    @(negedge clk);
    check_dark("held_reset");
    reset = 1'b0;
    model_reset();
    repeat (30) tick();

    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) din[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) din[5] = 4'($urandom_range(0, 1));
      sec_tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) blank = !blank;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1 check_dark("rand_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
